spi_master: RTL

SPI_MASTER -- requirements
Module: spi_master

---
 rtl/spi_pkg.sv | 19 +
 rtl/spi_clk_div.sv | 39 +++
 rtl/spi_master.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared types and defaults for the mode-3 SPI master.
package spi_pkg;

  localparam int SPI_FRAME_BITS_DEF = 32;
  localparam int SPI_CLK_DIV_DEF    = 8;

  // Mode 3: SCK idles high, data sampled on the rising edge.
  localparam logic SPI_CPOL = 1'b1;
  localparam logic SPI_CPHA = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } spi_state_e;

endpackage

// File: rtl/spi_clk_div.sv
// Half-period tick generator: one-cycle tick every CLK_DIV enabled cycles.
module spi_clk_div
  import spi_pkg::*;
#(
  parameter int CLK_DIV = SPI_CLK_DIV_DEF
) (
  input  logic clk_i,
  input  logic srst_i,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  // A clear restarts the phase, so it also suppresses a coincident tick.
  assign tick_o = en_i && !clr_i && (cnt_q == CNT_LAST);

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_master.sv
// SPI master, mode 3 (CPOL=1, CPHA=1), MSB first, fixed FRAME_BITS per SSEL-low frame.
// Define SPI_MASTER_LOOPBACK_EN to feed the receive shifter from MOSI instead of MISO.
module spi_master
  import spi_pkg::*;
#(
  parameter int FRAME_BITS = SPI_FRAME_BITS_DEF,
  parameter int CLK_DIV    = SPI_CLK_DIV_DEF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic [FRAME_BITS-1:0] TX_DATA,
  output logic [FRAME_BITS-1:0] RX_DATA,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  SCK,
  output logic                  SSEL,
  output logic                  MOSI,
  input  logic                  MISO
);

  localparam int BW = $clog2(FRAME_BITS + 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_BITS);

  spi_state_e            state_q, state_d;
  logic [FRAME_BITS-1:0] tx_sh_q, tx_sh_d;
  logic [FRAME_BITS-1:0] rx_sh_q, rx_sh_d;
  logic [FRAME_BITS-1:0] rx_data_q, rx_data_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic                  sck_q, sck_d;
  logic                  ssel_q, ssel_d;
  logic                  mosi_q, mosi_d;
  logic                  done_q, done_d;
  logic                  tick;
  logic                  accept;
  logic                  rx_bit;

  assign accept = (state_q == ST_IDLE) && START;

  spi_clk_div #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_div (
    .clk_i (CLK),
    .srst_i(RST),
    .en_i  (BUSY),
    .clr_i (accept),
    .tick_o(tick)
  );

`ifdef SPI_MASTER_LOOPBACK_EN
  logic unused_miso;
  assign unused_miso = MISO;
  assign rx_bit      = mosi_q;
`else
  assign rx_bit = MISO;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      tx_sh_q   <= '0;
      rx_sh_q   <= '0;
      rx_data_q <= '0;
      bit_cnt_q <= '0;
      sck_q     <= SPI_CPOL;
      ssel_q    <= 1'b1;
      mosi_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_sh_q   <= tx_sh_d;
      rx_sh_q   <= rx_sh_d;
      rx_data_q <= rx_data_d;
      bit_cnt_q <= bit_cnt_d;
      sck_q     <= sck_d;
      ssel_q    <= ssel_d;
      mosi_q    <= mosi_d;
      done_q    <= done_d;
    end
  end

  // SHIFT keeps the trailing high half-period after the last rise before HOLD.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (START) state_d = ST_SETUP;
      ST_SETUP: if (tick) state_d = ST_SHIFT;
      ST_SHIFT: if (tick && sck_q && (bit_cnt_q == BIT_LAST)) state_d = ST_HOLD;
      ST_HOLD:  if (tick) state_d = ST_GAP;
      ST_GAP:   if (tick) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    tx_sh_d   = tx_sh_q;
    rx_sh_d   = rx_sh_q;
    rx_data_d = rx_data_q;
    bit_cnt_d = bit_cnt_q;
    sck_d     = sck_q;
    ssel_d    = ssel_q;
    mosi_d    = mosi_q;
    done_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        sck_d = SPI_CPOL;
        if (START) begin
          tx_sh_d   = TX_DATA;
          rx_sh_d   = '0;
          bit_cnt_d = '0;
          ssel_d    = 1'b0;
          mosi_d    = TX_DATA[FRAME_BITS-1];
        end
      end
      ST_SETUP: begin
        // First fall: the MSB is already on MOSI.
        if (tick) sck_d = 1'b0;
      end
      ST_SHIFT: begin
        if (tick) begin
          if (!sck_q) begin
            sck_d     = 1'b1;
            rx_sh_d   = {rx_sh_q[FRAME_BITS-2:0], rx_bit};
            bit_cnt_d = bit_cnt_q + 1'b1;
          end else if (bit_cnt_q != BIT_LAST) begin
            sck_d   = 1'b0;
            tx_sh_d = {tx_sh_q[FRAME_BITS-2:0], 1'b0};
            mosi_d  = tx_sh_q[FRAME_BITS-2];
          end
        end
      end
      ST_HOLD: begin
        if (tick) begin
          ssel_d    = 1'b1;
          mosi_d    = 1'b0;
          done_d    = 1'b1;
          rx_data_d = rx_sh_q;
        end
      end
      ST_GAP: begin
      end
      default: begin
      end
    endcase
  end

  assign RX_DATA = rx_data_q;
  assign BUSY    = (state_q != ST_IDLE);
  assign DONE    = done_q;
  assign SCK     = sck_q;
  assign SSEL    = ssel_q;
  assign MOSI    = mosi_q;

endmodule
